request_unit: RTL and testbench
===============================

# request_unit

Multicycle memory sequencer on the far side of the control unit's `dREN`/`dWEN`/`datomic`/`cpu_halt` outputs. It fetches instructions through the instruction port and holds each one stable for decode. It issues the decoded data request on the data port and waits for the hit, then pulses the PC/register-file advance. It also owns the LL/SC link register, sits between the control unit and the cache/memory ports, and produces the instruction word the control unit consumes as `imemload`.

## Interface
Parameters:
- none; all words are `word_t` (32 bits) from `cpu_types_pkg`

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset; one clock; reset is asynchronous and active-high
- cu_dREN  in  1  control unit load request, decoded from `instr`
- cu_dWEN  in  1  control unit store request
- cu_datomic  in  1  LL (with cu_dREN) / SC (with cu_dWEN)
- cu_halt  in  1  control unit halt decode
- dmemaddr  in  32  data address from ALU
- dmemstore  in  32  store data (rdat2)
- iREN  out  1  instruction read request
- imemaddr_ack  in  1  not used; reserved, tie 0
- ihit  in  1  instruction read complete this cycle
- imemload  in  32  instruction from memory, valid with ihit
- dREN  out  1  data read request
- dWEN  out  1  data write request
- daddr  out  32  data address to memory
- dstore  out  32  data to memory
- dhit  in  1  data access complete this cycle
- dmemload  in  32  load data, valid with dhit
- instr  out  32  latched instruction to control unit
- ld_data  out  32  latched load result / SC result
- adv  out  1  one-cycle pulse: commit writeback, advance PC
- halt  out  1  sticky halt

## Operation
- State register: FETCH, EXEC, DATA, HALT.
- FETCH: iREN=1. On ihit, instr←imemload and go to EXEC. Otherwise stay.
- EXEC: iREN=0. The control unit decodes `instr` combinationally. Priority order:
  - cu_halt → HALT.
  - SC with link failed → ld_data←0, adv=1 → FETCH. No memory access.
  - cu_dWEN → DATA (write).
  - cu_dREN → DATA (read).
  - otherwise adv=1 → FETCH.
- If cu_dREN and cu_dWEN are both set, the write wins.
- DATA: dREN or dWEN held from the operation latched on EXEC exit. daddr/dstore come from registers captured on EXEC exit. On dhit:
  - read: ld_data←dmemload.
  - SC: ld_data←1.
  - In both cases adv=1 and next state is FETCH.
- Link register: link_valid (1b), link_addr (32b).
  - LL completing (dhit) sets link_valid=1, link_addr=daddr.
  - SC completing or failing clears link_valid.
  - A plain store completing with daddr==link_addr clears link_valid.
  - SC succeeds iff link_valid && link_addr==dmemaddr, evaluated in EXEC.
- HALT: absorbing. halt=1, no requests issued, adv=0. Only RST exits.
- datomic is not forwarded to memory; atomicity is resolved locally.

## Timing
- Reset values: state=FETCH, instr=0, ld_data=0, daddr=0, dstore=0, link_valid=0, link_addr=0, adv=0, halt=0. dREN=dWEN=0.
- iREN=1 during reset release, because the state is FETCH.
- Outputs iREN/dREN/dWEN/adv/halt decode from registered state only; there is no input→output combinational path except adv in EXEC (depends on cu_* decode).
- Non-memory instruction: minimum 2 cycles (FETCH with same-cycle ihit, then EXEC).
- Load/store: minimum 3 cycles (FETCH, EXEC, DATA with same-cycle dhit).
- Wait states extend FETCH/DATA indefinitely. Requests and address stay stable until the hit.
- ihit outside FETCH and dhit outside DATA are ignored.
- instr changes only on the FETCH→EXEC edge.
- ld_data is valid from the cycle adv is asserted until the next completing load/SC.
- RST asserted mid-DATA drops the request asynchronously (dREN/dWEN fall without a clock). A pending hit is discarded.

## Test plan
- Reset with iREN check: hold RST, then release. Expect iREN=1, dREN=dWEN=0, adv=0, halt=0. Give ihit with imemload=0x2008000A. Next cycle instr=0x2008000A and adv=1 with cu_* all 0.
- Load with wait states: cu_dREN=1, dmemaddr=0x100. Expect dREN=1, daddr=0x100 held across 3 dhit=0 cycles. Then dhit with dmemload=0xDEADBEEF gives ld_data=0xDEADBEEF and a single adv pulse.
- Store: cu_dWEN=1, dmemaddr=0x200, dmemstore=0x12345678. Expect dWEN=1, dstore=0x12345678 until dhit. Exactly one adv; dREN stays 0.
- LL/SC success: LL to 0x300 completes, then SC to 0x300. Expect dWEN asserted, then ld_data=1, then link_valid cleared. A second SC to 0x300 expects no dWEN, ld_data=0, and adv in EXEC.
- Link break: LL 0x300, then plain store to 0x300, then SC 0x300. Expect SC fails with no dWEN and ld_data=0. LL 0x300, then store to 0x304, then SC succeeds.
- Halt and reset mid-op: cu_halt in EXEC gives halt=1 and iREN=0 forever despite ihit. Separately, assert RST during DATA. dWEN drops immediately, state returns to FETCH, and a later dhit is ignored.

Source files
------------

// File: rtl/request_unit_if.sv
// Signal bundle between the request unit, the control unit decode and the
// instruction/data memory ports. The request unit connects through the master modport.
interface request_unit_if;
    logic        cu_dREN;
    logic        cu_dWEN;
    logic        cu_datomic;
    logic        cu_halt;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        iREN;
    logic        imemaddr_ack;
    logic        ihit;
    logic [31:0] imemload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic [31:0] instr;
    logic [31:0] ld_data;
    logic        adv;
    logic        halt;

    modport master (
        input  cu_dREN, cu_dWEN, cu_datomic, cu_halt, dmemaddr, dmemstore,
        input  imemaddr_ack, ihit, imemload, dhit, dmemload,
        output iREN, dREN, dWEN, daddr, dstore, instr, ld_data, adv, halt
    );

    modport slave (
        output cu_dREN, cu_dWEN, cu_datomic, cu_halt, dmemaddr, dmemstore,
        output imemaddr_ack, ihit, imemload, dhit, dmemload,
        input  iREN, dREN, dWEN, daddr, dstore, instr, ld_data, adv, halt
    );
endinterface

// File: rtl/request_unit.sv
// Multicycle fetch/execute/data sequencer with a local LL/SC link register.
// Atomicity is resolved here; memory only ever sees plain reads and writes.
module request_unit (
    input  logic          CLK,
    input  logic          RST,
    request_unit_if.master bus
);
    typedef enum logic [1:0] {FETCH, EXEC, DATA, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ldData_q, ldData_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] dstore_q, dstore_d;
    logic        opWrite_q, opWrite_d;
    logic        opAtomic_q, opAtomic_d;
    logic        linkValid_q, linkValid_d;
    logic [31:0] linkAddr_q, linkAddr_d;
    logic        advData_q, advData_d;
    logic        advExec;
    logic        scFail;
    logic        unusedAck;

    assign unusedAck = bus.imemaddr_ack;

    // A store-conditional with the write bit set wins over any read decode.
    assign scFail = bus.cu_dWEN && bus.cu_datomic &&
                    !(linkValid_q && (linkAddr_q == bus.dmemaddr));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= FETCH;
            instr_q     <= '0;
            ldData_q    <= '0;
            daddr_q     <= '0;
            dstore_q    <= '0;
            opWrite_q   <= 1'b0;
            opAtomic_q  <= 1'b0;
            linkValid_q <= 1'b0;
            linkAddr_q  <= '0;
            advData_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            ldData_q    <= ldData_d;
            daddr_q     <= daddr_d;
            dstore_q    <= dstore_d;
            opWrite_q   <= opWrite_d;
            opAtomic_q  <= opAtomic_d;
            linkValid_q <= linkValid_d;
            linkAddr_q  <= linkAddr_d;
            advData_q   <= advData_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        ldData_d    = ldData_q;
        daddr_d     = daddr_q;
        dstore_d    = dstore_q;
        opWrite_d   = opWrite_q;
        opAtomic_d  = opAtomic_q;
        linkValid_d = linkValid_q;
        linkAddr_d  = linkAddr_q;
        advData_d   = 1'b0;
        advExec     = 1'b0;
        case (state_q)
            FETCH: begin
                if (bus.ihit) begin
                    instr_d = bus.imemload;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (bus.cu_halt) begin
                    state_d = HALT;
                end else if (scFail) begin
                    ldData_d    = '0;
                    linkValid_d = 1'b0;
                    advExec     = 1'b1;
                    state_d     = FETCH;
                end else if (bus.cu_dWEN || bus.cu_dREN) begin
                    opWrite_d  = bus.cu_dWEN;
                    opAtomic_d = bus.cu_datomic;
                    daddr_d    = bus.dmemaddr;
                    dstore_d   = bus.dmemstore;
                    state_d    = DATA;
                end else begin
                    advExec = 1'b1;
                    state_d = FETCH;
                end
            end
            DATA: begin
                // The data-side advance is registered so ld_data is already valid when adv rises.
                if (bus.dhit) begin
                    advData_d = 1'b1;
                    state_d   = FETCH;
                    if (opWrite_q) begin
                        if (opAtomic_q) begin
                            ldData_d    = 32'd1;
                            linkValid_d = 1'b0;
                        end else if (daddr_q == linkAddr_q) begin
                            linkValid_d = 1'b0;
                        end
                    end else begin
                        ldData_d = bus.dmemload;
                        if (opAtomic_q) begin
                            linkValid_d = 1'b1;
                            linkAddr_d  = daddr_q;
                        end
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign bus.iREN    = (state_q == FETCH);
    assign bus.dREN    = (state_q == DATA) && !opWrite_q;
    assign bus.dWEN    = (state_q == DATA) && opWrite_q;
    assign bus.halt    = (state_q == HALT);
    assign bus.adv     = advExec || advData_q;
    assign bus.instr   = instr_q;
    assign bus.ld_data = ldData_q;
    assign bus.daddr   = daddr_q;
    assign bus.dstore  = dstore_q;
endmodule

// File: tb/tb_request_unit.sv
// Directed self-checking bench for request_unit: fetch, load/store, LL/SC link
// handling, halt and asynchronous reset during a data access.
module tb_request_unit;
    logic CLK;
    logic RST;
    int   vectors;
    int   miscompares;

    request_unit_if bus ();

    request_unit dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Free-running clock; stimulus changes and sampling happen around the falling edge.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clearCu();
        bus.cu_dREN    = 1'b0;
        bus.cu_dWEN    = 1'b0;
        bus.cu_datomic = 1'b0;
        bus.cu_halt    = 1'b0;
    endtask

    // Enter at a falling edge in FETCH; leave at the next falling edge in EXEC.
    task automatic fetchInstr(input logic [31:0] word);
        bus.ihit     = 1'b1;
        bus.imemload = word;
        @(negedge CLK);
        bus.ihit     = 1'b0;
        bus.imemload = '0;
    endtask

    // One full memory instruction with a zero-wait hit; leaves in FETCH on the adv cycle.
    task automatic memOp(input logic rd, input logic wr, input logic at,
                         input logic [31:0] addr, input logic [31:0] st,
                         input logic [31:0] ld);
        fetchInstr(32'h0);
        bus.cu_dREN    = rd;
        bus.cu_dWEN    = wr;
        bus.cu_datomic = at;
        bus.dmemaddr   = addr;
        bus.dmemstore  = st;
        @(negedge CLK);
        clearCu();
        bus.dhit     = 1'b1;
        bus.dmemload = ld;
        @(negedge CLK);
        bus.dhit     = 1'b0;
        bus.dmemload = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        clearCu();
        bus.dmemaddr = '0; bus.dmemstore = '0; bus.imemaddr_ack = 1'b0;
        bus.ihit = 1'b0; bus.imemload = '0; bus.dhit = 1'b0; bus.dmemload = '0;
        repeat (2) @(negedge CLK);
        #1;
        vectors++; if (bus.iREN !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_iREN: got %b expected 1", bus.iREN); end
        vectors++; if ({bus.dREN, bus.dWEN, bus.adv, bus.halt} !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {bus.dREN, bus.dWEN, bus.adv, bus.halt}); end
        vectors++; if ({bus.instr, bus.ld_data, bus.daddr, bus.dstore} !== 128'h0) begin miscompares++; $display("[TB] FAIL reset_regs: got %h expected 0", {bus.instr, bus.ld_data, bus.daddr, bus.dstore}); end
        @(negedge CLK);
        RST = 1'b0;
        fetchInstr(32'h2008000A);
        #1;
        vectors++; if (bus.instr !== 32'h2008000A) begin miscompares++; $display("[TB] FAIL first_instr: got %h expected 2008000a", bus.instr); end
        vectors++; if ({bus.adv, bus.iREN} !== 2'b10) begin miscompares++; $display("[TB] FAIL alu_adv: got adv,iREN=%b expected 10", {bus.adv, bus.iREN}); end
        @(negedge CLK);
        #1;
        vectors++; if ({bus.adv, bus.iREN} !== 2'b01) begin miscompares++; $display("[TB] FAIL alu_refetch: got adv,iREN=%b expected 01", {bus.adv, bus.iREN}); end
    endtask

    task automatic test_load();
        fetchInstr(32'h8D090100);
        bus.cu_dREN  = 1'b1;
        bus.dmemaddr = 32'h100;
        #1;
        vectors++; if (bus.adv !== 1'b0) begin miscompares++; $display("[TB] FAIL load_exec_adv: got %b expected 0", bus.adv); end
        @(negedge CLK);
        clearCu();
        bus.dmemaddr = 32'hFFF;
        bus.ihit     = 1'b1;
        bus.imemload = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if ({bus.dREN, bus.dWEN, bus.adv} !== 3'b100) begin miscompares++; $display("[TB] FAIL load_wait%0d_ctrl: got dREN,dWEN,adv=%b expected 100", i, {bus.dREN, bus.dWEN, bus.adv}); end
            vectors++; if (bus.daddr !== 32'h100) begin miscompares++; $display("[TB] FAIL load_wait%0d_addr: got %h expected 00000100", i, bus.daddr); end
            @(negedge CLK);
        end
        vectors++; if (bus.instr !== 32'h8D090100) begin miscompares++; $display("[TB] FAIL load_instr_hold: got %h expected 8d090100", bus.instr); end
        bus.ihit     = 1'b0;
        bus.imemload = '0;
        bus.dhit     = 1'b1;
        bus.dmemload = 32'hDEADBEEF;
        @(negedge CLK);
        bus.dhit = 1'b0;
        #1;
        vectors++; if (bus.ld_data !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL load_data: got %h expected deadbeef", bus.ld_data); end
        vectors++; if ({bus.adv, bus.dREN, bus.iREN} !== 3'b101) begin miscompares++; $display("[TB] FAIL load_adv: got adv,dREN,iREN=%b expected 101", {bus.adv, bus.dREN, bus.iREN}); end
        @(negedge CLK);
        #1;
        vectors++; if (bus.adv !== 1'b0) begin miscompares++; $display("[TB] FAIL load_adv_single: got %b expected 0", bus.adv); end
    endtask

    task automatic test_store();
        fetchInstr(32'hAD090200);
        bus.cu_dWEN   = 1'b1;
        bus.dmemaddr  = 32'h200;
        bus.dmemstore = 32'h12345678;
        @(negedge CLK);
        clearCu();
        bus.dmemstore = 32'h0;
        #1;
        vectors++; if ({bus.dWEN, bus.dREN, bus.adv} !== 3'b100) begin miscompares++; $display("[TB] FAIL store_ctrl: got dWEN,dREN,adv=%b expected 100", {bus.dWEN, bus.dREN, bus.adv}); end
        vectors++; if (bus.dstore !== 32'h12345678) begin miscompares++; $display("[TB] FAIL store_data: got %h expected 12345678", bus.dstore); end
        vectors++; if (bus.daddr !== 32'h200) begin miscompares++; $display("[TB] FAIL store_addr: got %h expected 00000200", bus.daddr); end
        @(negedge CLK);
        bus.dhit = 1'b1;
        @(negedge CLK);
        bus.dhit = 1'b0;
        #1;
        vectors++; if ({bus.adv, bus.dWEN, bus.dREN} !== 3'b100) begin miscompares++; $display("[TB] FAIL store_adv: got adv,dWEN,dREN=%b expected 100", {bus.adv, bus.dWEN, bus.dREN}); end
        vectors++; if (bus.ld_data !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL store_keeps_ld: got %h expected deadbeef", bus.ld_data); end
        @(negedge CLK);
        #1;
        vectors++; if (bus.adv !== 1'b0) begin miscompares++; $display("[TB] FAIL store_adv_single: got %b expected 0", bus.adv); end
    endtask

    task automatic test_write_wins();
        fetchInstr(32'h0);
        bus.cu_dREN  = 1'b1;
        bus.cu_dWEN  = 1'b1;
        bus.dmemaddr = 32'h240;
        @(negedge CLK);
        clearCu();
        #1;
        vectors++; if ({bus.dWEN, bus.dREN} !== 2'b10) begin miscompares++; $display("[TB] FAIL write_wins: got dWEN,dREN=%b expected 10", {bus.dWEN, bus.dREN}); end
        @(negedge CLK);
        bus.dhit = 1'b1;
        @(negedge CLK);
        bus.dhit = 1'b0;
    endtask

    // Issues an SC to addr from FETCH and checks the success or failure path.
    task automatic scCheck(input logic [31:0] addr, input logic expectOk, input string tag);
        fetchInstr(32'hE1090000);
        bus.cu_dWEN    = 1'b1;
        bus.cu_datomic = 1'b1;
        bus.dmemaddr   = addr;
        bus.dmemstore  = 32'hAB;
        #1;
        vectors++; if (bus.adv !== !expectOk) begin miscompares++; $display("[TB] FAIL %s_exec_adv: got %b expected %b", tag, bus.adv, !expectOk); end
        @(negedge CLK);
        clearCu();
        #1;
        vectors++; if (bus.dWEN !== expectOk) begin miscompares++; $display("[TB] FAIL %s_dWEN: got %b expected %b", tag, bus.dWEN, expectOk); end
        if (expectOk) begin
            bus.dhit = 1'b1;
            @(negedge CLK);
            bus.dhit = 1'b0;
            #1;
            vectors++; if ({bus.ld_data, bus.adv} !== {32'd1, 1'b1}) begin miscompares++; $display("[TB] FAIL %s_result: got ld_data=%h adv=%b expected 00000001 1", tag, bus.ld_data, bus.adv); end
        end else begin
            vectors++; if ({bus.ld_data, bus.iREN, bus.adv} !== {32'd0, 1'b1, 1'b0}) begin miscompares++; $display("[TB] FAIL %s_result: got ld_data=%h iREN=%b adv=%b expected 00000000 1 0", tag, bus.ld_data, bus.iREN, bus.adv); end
        end
        @(negedge CLK);
    endtask

    task automatic test_llsc();
        memOp(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 32'h55);
        #1;
        vectors++; if (bus.ld_data !== 32'h55) begin miscompares++; $display("[TB] FAIL ll_data: got %h expected 00000055", bus.ld_data); end
        scCheck(32'h300, 1'b1, "sc_first");
        scCheck(32'h300, 1'b0, "sc_second");
    endtask

    task automatic test_link_break();
        memOp(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 32'h66);
        memOp(1'b0, 1'b1, 1'b0, 32'h300, 32'h9, 32'h0);
        scCheck(32'h300, 1'b0, "sc_after_store");
        memOp(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 32'h77);
        memOp(1'b0, 1'b1, 1'b0, 32'h304, 32'h9, 32'h0);
        scCheck(32'h300, 1'b1, "sc_other_store");
        memOp(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 32'h88);
        scCheck(32'h304, 1'b0, "sc_wrong_addr");
    endtask

    task automatic test_halt();
        fetchInstr(32'hFFFFFFFF);
        bus.cu_halt = 1'b1;
        bus.cu_dREN = 1'b1;
        #1;
        vectors++; if (bus.adv !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_exec_adv: got %b expected 0", bus.adv); end
        @(negedge CLK);
        clearCu();
        bus.ihit = 1'b1;
        bus.dhit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if ({bus.halt, bus.iREN, bus.dREN, bus.dWEN, bus.adv} !== 5'b10000) begin miscompares++; $display("[TB] FAIL halt_hold%0d: got halt,iREN,dREN,dWEN,adv=%b expected 10000", i, {bus.halt, bus.iREN, bus.dREN, bus.dWEN, bus.adv}); end
            @(negedge CLK);
        end
        bus.ihit = 1'b0;
        bus.dhit = 1'b0;
        RST = 1'b1;
        #1;
        vectors++; if ({bus.halt, bus.iREN} !== 2'b01) begin miscompares++; $display("[TB] FAIL halt_reset_exit: got halt,iREN=%b expected 01", {bus.halt, bus.iREN}); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset_mid_data();
        fetchInstr(32'h0);
        bus.cu_dWEN   = 1'b1;
        bus.dmemaddr  = 32'h400;
        bus.dmemstore = 32'h5A5A5A5A;
        @(negedge CLK);
        clearCu();
        #1;
        vectors++; if (bus.dWEN !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_dWEN_before: got %b expected 1", bus.dWEN); end
        #2;
        RST = 1'b1;
        #1;
        vectors++; if ({bus.dWEN, bus.iREN} !== 2'b01) begin miscompares++; $display("[TB] FAIL mid_async_drop: got dWEN,iREN=%b expected 01", {bus.dWEN, bus.iREN}); end
        @(negedge CLK);
        RST = 1'b0;
        bus.dhit     = 1'b1;
        bus.dmemload = 32'hCAFEF00D;
        @(negedge CLK);
        bus.dhit = 1'b0;
        #1;
        vectors++; if ({bus.iREN, bus.dWEN, bus.adv} !== 3'b100) begin miscompares++; $display("[TB] FAIL mid_late_dhit: got iREN,dWEN,adv=%b expected 100", {bus.iREN, bus.dWEN, bus.adv}); end
        vectors++; if ({bus.ld_data, bus.daddr} !== 64'h0) begin miscompares++; $display("[TB] FAIL mid_regs: got ld_data=%h daddr=%h expected 0 0", bus.ld_data, bus.daddr); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_load();
        test_store();
        test_write_wins();
        test_llsc();
        test_link_break();
        test_halt();
        test_reset_mid_data();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
